// File: rtl/mem_pkg.sv
// Package: mem_pkg
// Shared definitions for the single-port RAM and its two-requester arbiter:
//   - FSM state encoding of ram_arbiter
//   - number of requesters
//   - default word/address widths used by ram and ram_arbiter
//   - small helper to turn a requester index into a one-hot vector
package mem_pkg;

    localparam int NUM_REQ        = 2;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Interface: ram_arbiter_if
// Requester-side bus of ram_arbiter. Both requesters share one bundle; the
// per-requester fields are packed side by side (requester i in slice i).
//   req     requester i has a pending access
//   we      1 = write, 0 = read (valid while req[i] is high)
//   addr    addr[i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata   wdata[i*DATA_WIDTH +: DATA_WIDTH]
//   gnt     one-cycle accept pulse per requester
//   rvalid  one-cycle read-result pulse per requester
//   rd_data shared read result, qualified by rvalid
//   busy    arbiter is not idle
// Modports: master = the client side, slave = the arbiter.
interface ram_arbiter_if
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          busy;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rd_data, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rd_data, busy
    );
endinterface

// File: rtl/ram.sv
// Module: ram
// Single-port synchronous RAM. Write and read share one address; the read
// returns the word stored before a same-cycle write, one cycle after the
// address is presented.
// Ports:
//   clk     in   clock
//   wr_en   in   write enable
//   addr    in   word address
//   w_data  in   write data
//   r_data  out  registered read data
module ram
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= w_data;
        end
        r_data <= mem_q[addr];
    end
endmodule

// File: rtl/ram_arbiter_arb2.sv
// Module: rr_arb2
// Two-way winner select for ram_arbiter.
// Default build: round-robin. A lone requester wins; on a tie the requester
// that was not granted last wins. rr_last resets to 1 so requester 0 takes
// the first tie after reset.
// With RAM_ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie and no
// history register exists (clk/rst/upd_i ports are absent).
// Ports:
//   clk    in   clock (round-robin build only)
//   rst    in   synchronous active-high reset (round-robin build only)
//   upd_i  in   a grant is being issued this cycle (round-robin build only)
//   req_i  in   pending requests
//   win_o  out  index of the winning requester (meaningful when req_i != 0)
module rr_arb2 (
`ifndef RAM_ARB_FIXED_PRIO_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       upd_i,
`endif
    input  logic [1:0] req_i,
    output logic       win_o
);
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic rr_last_q;
    logic rr_last_d;

    always_comb begin
        win_o = 1'b0;
        if (req_i == 2'b10) begin
            win_o = 1'b1;
        end else if (req_i == 2'b11) begin
            win_o = ~rr_last_q;
        end
    end

    assign rr_last_d = upd_i ? win_o : rr_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    // Requester 1 only wins when requester 0 is silent.
    assign win_o = ~req_i[0] & req_i[1];
`endif
endmodule

// File: rtl/ram_arbiter.sv
// Module: ram_arbiter
// Two-requester arbiter/sequencer in front of a single-port synchronous RAM.
// One access (write or read) is accepted per grant; the RAM ports are driven
// from registers and read data comes back with a per-requester valid pulse.
//   write: IDLE -> ACCESS -> IDLE                (next request sampled 2 cycles later)
//   read : IDLE -> ACCESS -> RDWAIT -> RESP -> IDLE
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (fixed priority, requester 0
// wins ties) -- handled inside rr_arb2.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   bus          slave modport of ram_arbiter_if (req/we/addr/wdata in,
//                gnt/rvalid/rd_data/busy out)
//   ram_wr_en    out  RAM wr_en
//   ram_addr     out  RAM addr
//   ram_wr_data  out  RAM w_data
//   ram_rd_data  in   RAM r_data (valid one cycle after the address)
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_if.slave          bus,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);
    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  busy_q, busy_d;
    logic                  ram_wr_en_q, ram_wr_en_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
    logic                  sel_q, sel_d;     // requester being served
    logic                  is_wr_q, is_wr_d; // access being served is a write

    logic win;
    logic grant;

    rr_arb2 u_arb (
`ifndef RAM_ARB_FIXED_PRIO_EN
        .clk   (clk),
        .rst   (rst),
        .upd_i (grant),
`endif
        .req_i (bus.req),
        .win_o (win)
    );

    always_comb begin
        state_d       = state_q;
        gnt_d         = '0;
        rvalid_d      = '0;
        rd_data_d     = rd_data_q;
        ram_wr_en_d   = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        sel_d         = sel_q;
        is_wr_d       = is_wr_q;
        grant         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant         = 1'b1;
                    ram_addr_d    = win ? bus.addr[ADDR_WIDTH +: ADDR_WIDTH]
                                        : bus.addr[0 +: ADDR_WIDTH];
                    ram_wr_data_d = win ? bus.wdata[DATA_WIDTH +: DATA_WIDTH]
                                        : bus.wdata[0 +: DATA_WIDTH];
                    ram_wr_en_d   = bus.we[win];
                    gnt_d         = onehot2(win);
                    sel_d         = win;
                    is_wr_d       = bus.we[win];
                    state_d       = ST_ACCESS;
                end
            end
            // RAM performs the access at the edge closing this cycle.
            ST_ACCESS: begin
                state_d = is_wr_q ? ST_IDLE : ST_RDWAIT;
            end
            // RAM read data is on ram_rd_data now.
            ST_RDWAIT: begin
                rd_data_d = ram_rd_data;
                rvalid_d  = onehot2(sel_q);
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy is registered, so it follows the state being entered.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            rvalid_q      <= '0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
            ram_wr_en_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            sel_q         <= 1'b0;
            is_wr_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rvalid_q      <= rvalid_d;
            rd_data_q     <= rd_data_d;
            busy_q        <= busy_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            sel_q         <= sel_d;
            is_wr_q       <= is_wr_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rd_data = rd_data_q;
    assign bus.busy    = busy_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
endmodule
